// File: rtl/sig_reorder_pkg.sv
// Shared definitions for the signature reorder buffer: level encodings,
// per-level word counts and the FSM state type.
package sig_reorder_pkg;

    localparam logic [2:0] LVL2 = 3'b010;
    localparam logic [2:0] LVL3 = 3'b011;
    localparam logic [2:0] LVL5 = 3'b101;

    localparam int C_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        PASS_C,
        DRAIN_PREP,
        DRAIN
    } state_t;

    // Anything that is not a recognised level falls back to level 2.
    function automatic logic [2:0] norm_lvl(input logic [2:0] lvl);
        return ((lvl == LVL3) || (lvl == LVL5)) ? lvl : LVL2;
    endfunction

    // z packs 256*l coefficients of (log2(gamma1)+1) bits each.
    function automatic int z_words(input logic [2:0] lvl, input int w);
        int bits;
        case (lvl)
            LVL3:    bits = 256 * 5 * 20;
            LVL5:    bits = 256 * 7 * 20;
            default: bits = 256 * 4 * 18;
        endcase
        return (bits + w - 1) / w;
    endfunction

    // h is omega + k bytes.
    function automatic int h_words(input logic [2:0] lvl, input int w);
        int bits;
        case (lvl)
            LVL3:    bits = (55 + 6) * 8;
            LVL5:    bits = (75 + 8) * 8;
            default: bits = (80 + 4) * 8;
        endcase
        return (bits + w - 1) / w;
    endfunction

endpackage

// File: rtl/sig_buf_ram.sv
// Simple dual-port buffer: one synchronous write port and one read port
// with a registered output, shaped for block-RAM inference.
module sig_buf_ram #(
    parameter int W     = 64,
    parameter int DEPTH = 576
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sig_reorder.sv
// Signature reorder buffer: stores z||h from the core, forwards c straight
// through, then replays z||h so the consumer sees c||z||h.
module sig_reorder
    import sig_reorder_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 576
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   sec_lvl,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int PW = $clog2(DEPTH);

    state_t        state, state_nxt;
    logic [2:0]    lvl;
    logic [PW-1:0] wr_ptr, rd_ptr, rd_addr, last_idx;
    logic [1:0]    c_cnt;
    logic          wr_en, rd_en, at_last;
    logic [W-1:0]  rd_data_p1;

    assign last_idx = PW'(z_words(lvl, W) + h_words(lvl, W) - 1);
    assign at_last  = (rd_ptr == last_idx);
    assign busy     = (state != IDLE);
    assign wr_en    = (state == CAPTURE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = rd_ptr + PW'(1);
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                in_ready = 1'b1;
                if (in_valid && (wr_ptr == last_idx))
                    state_nxt = PASS_C;
            end
            PASS_C: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                out_data  = in_data;
                if (in_valid && out_ready && (c_cnt == 2'(C_WORDS - 1)))
                    state_nxt = DRAIN_PREP;
            end
            DRAIN_PREP: begin
                rd_en   = 1'b1;
                rd_addr = '0;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = rd_data_p1;
                out_last  = at_last;
                // Reading only on a transfer keeps the registered word stable under backpressure.
                if (out_ready) begin
                    if (at_last)
                        state_nxt = IDLE;
                    else
                        rd_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl    <= LVL2;
            wr_ptr <= '0;
            rd_ptr <= '0;
            c_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lvl    <= norm_lvl(sec_lvl);
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        c_cnt  <= '0;
                    end
                end
                CAPTURE: begin
                    if (in_valid)
                        wr_ptr <= wr_ptr + PW'(1);
                end
                PASS_C: begin
                    if (in_valid && out_ready)
                        c_cnt <= c_cnt + 2'd1;
                end
                DRAIN_PREP: rd_ptr <= '0;
                DRAIN: begin
                    if (out_ready && !at_last)
                        rd_ptr <= rd_ptr + PW'(1);
                end
                default: ;
            endcase
        end
    end

    // buffer write in CAPTURE / registered read feeding DRAIN (p1)
    sig_buf_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data_p1)
    );

endmodule

// File: tb/tb_sig_reorder.sv
// Bench for sig_reorder: table of signature runs checked against a queue model
// of the c||z||h reordering, plus reset and back-to-back sequences.
module tb_sig_reorder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  sec_lvl;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;

    sig_reorder #(.W(64), .DEPTH(576)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sec_lvl   (sec_lvl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_g = 0;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    int n_chk  = 0;
    int n_pass = 0;

    int out_cnt, t_first_c_in, t_first_out, t_last_c_out, t_first_z_out, t_last_out;

    typedef struct {
        logic [2:0] code;
        int         rdy_pct;
        int         gap_pct;
        bit         det;
        bit         junk;
        bit         sdrain;
        int         exp_words;
        int         exp_cycles;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // One whole signature: the core streams z,h,c; the model expects c,z,h.
    task automatic run_sig(input logic [2:0] code, input int rdy_pct, input int gap_pct,
                           input bit det, input bit junk, input bit sdrain, input int rst_after);
        logic [63:0] src[$];
        logic [63:0] exp_q[$];
        int          zw, hw, nsrc, nexp, target;
        int          in_idx, out_idx, guard, busy_bad;
        bit          hold, stall, sdone;
        logic [63:0] stall_data;

        case (code)
            3'b011:  begin zw = 400; hw = 8;  end
            3'b101:  begin zw = 560; hw = 11; end
            default: begin zw = 288; hw = 11; end
        endcase
        for (int i = 0; i < zw; i++) src.push_back(det ? 64'(i) : {$urandom, $urandom});
        for (int i = 0; i < hw; i++) src.push_back(det ? 64'h1000 + 64'(i) : {$urandom, $urandom});
        for (int i = 0; i < 4;  i++) src.push_back(det ? 64'hC0 + 64'(i) : {$urandom, $urandom});
        for (int i = 0; i < 4; i++) exp_q.push_back(src[zw + hw + i]);
        for (int i = 0; i < zw + hw; i++) exp_q.push_back(src[i]);
        nsrc   = src.size();
        nexp   = exp_q.size();
        target = (rst_after > 0) ? rst_after : nexp;

        @(negedge clk);
        start = 1'b1; sec_lvl = code; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("busy_rise", busy, 1);
        check("in_ready_rise", in_ready, 1);

        in_idx = 0; out_idx = 0; guard = 0; busy_bad = 0;
        hold = 0; stall = 0; sdone = 0; stall_data = '0;
        t_first_c_in = -1; t_first_out = -1; t_last_c_out = -1; t_first_z_out = -1; t_last_out = -1;
        while (out_idx < target && guard < 20000) begin
            @(negedge clk);
            if (sdrain && !sdone && out_idx == 150) begin
                start = 1'b1; sec_lvl = 3'b101; sdone = 1;
            end else begin
                start = 1'b0;
            end
            if (!hold) begin
                if (in_idx < nsrc) begin
                    in_valid = ($urandom_range(99) >= gap_pct);
                    in_data  = src[in_idx];
                end else begin
                    in_valid = junk;
                    in_data  = 64'hDEAD;
                end
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_data);
            end
            if (in_idx >= nsrc && in_valid) check("in_ready_after_c", in_ready, 0);
            if (!busy) busy_bad++;
            if (out_valid && out_ready) begin
                if (out_idx == 0) begin
                    check("buffered_words", in_idx, zw + hw);
                    t_first_out = cyc_g;
                end
                if (out_idx == 3) t_last_c_out = cyc_g;
                if (out_idx == 4) t_first_z_out = cyc_g;
                check("out_data", out_data, exp_q[out_idx]);
                check("out_last", out_last, (out_idx == nexp - 1));
                t_last_out = cyc_g;
                out_idx++;
            end
            if (in_valid && in_ready && in_idx < nsrc) begin
                if (in_idx == zw + hw) t_first_c_in = cyc_g;
                in_idx++;
            end
            hold       = in_valid && !in_ready;
            stall      = out_valid && !out_ready;
            stall_data = out_data;
            guard++;
            if (rst_after > 0 && out_idx == rst_after) break;
            @(posedge clk);
        end
        start = 1'b0;
        check("busy_held", busy_bad, 0);
        out_cnt = out_idx;
        if (rst_after == 0) begin
            #1;
            check("busy_fall", busy, 0);
            check("idle_out_valid", out_valid, 0);
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        tbl[0] = '{3'b010, 100, 0,  1'b1, 1'b0, 1'b0, 303, 304};
        tbl[1] = '{3'b101, 50,  0,  1'b0, 1'b0, 1'b0, 575, 0};
        tbl[2] = '{3'b011, 100, 35, 1'b0, 1'b1, 1'b0, 412, 0};
        tbl[3] = '{3'b010, 70,  20, 1'b0, 1'b0, 1'b1, 303, 0};
        tbl[4] = '{3'b111, 100, 0,  1'b0, 1'b1, 1'b0, 303, 304};

        rst = 1'b1; start = 1'b0; sec_lvl = 3'b000;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            run_sig(tbl[i].code, tbl[i].rdy_pct, tbl[i].gap_pct, tbl[i].det,
                    tbl[i].junk, tbl[i].sdrain, 0);
            check("word_count", out_cnt, tbl[i].exp_words);
            if (tbl[i].exp_cycles != 0) begin
                check("pass_latency", t_first_out, t_first_c_in);
                check("bubble", t_first_z_out - t_last_c_out, 2);
                check("drain_cycles", t_last_out - t_first_c_in + 1, tbl[i].exp_cycles);
            end
            repeat (3) @(posedge clk);
        end

        // Reset in the middle of the replay, then a clean level-2 signature.
        run_sig(3'b010, 100, 0, 1'b1, 1'b0, 1'b0, 100);
        check("pre_rst_count", out_cnt, 100);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_last", out_last, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_busy", busy, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_sig(3'b010, 100, 0, 1'b1, 1'b0, 1'b0, 0);
        check("post_rst_words", out_cnt, 303);

        // Back-to-back: the second start lands the cycle after busy falls.
        run_sig(3'b010, 100, 0, 1'b1, 1'b0, 1'b0, 0);
        check("b2b_first_words", out_cnt, 303);
        run_sig(3'b011, 100, 0, 1'b0, 1'b0, 1'b0, 0);
        check("b2b_second_words", out_cnt, 412);
        check("b2b_c_not_early", (t_first_out >= t_first_c_in), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1, "timeout");
    end

endmodule
